// File: rtl/tdm_failover_ctrl.sv
// Primary/secondary TDM source failover controller: debounced switch to secondary,
// wait-to-restore revert, manual forcing, dual-fail mute, switch counting and sticky alarms.
module tdm_failover_ctrl #(
   parameter int HOLD_CYC = 48,
   parameter int WTR_CYC  = 4800
) (
   input  logic       FPGA_48MHz,
   input  logic       FPGA_rst,
   input  logic       pri_fail,
   input  logic       sec_fail,
   input  logic       revert_en,
   input  logic       force_req,
   input  logic       force_sel,
   input  logic       alm_clr,
   input  logic       cnt_clr,
   output logic       sel,
   output logic       mute,
   output logic       switch_pls,
   output logic [7:0] sw_cnt,
   output logic       pri_alm,
   output logic       sec_alm,
   output logic [2:0] state
);

   localparam int MAX_CYC = (HOLD_CYC > WTR_CYC) ? HOLD_CYC : WTR_CYC;
   localparam int TW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] WTR_LAST  = TW'(WTR_CYC - 1);

   typedef enum logic [2:0] {
      S_PRI  = 3'd0,
      S_HOLD = 3'd1,
      S_SEC  = 3'd2,
      S_WTR  = 3'd3,
      S_MUTE = 3'd4
   } state_t;

   state_t        st;
   state_t        nxt;
   state_t        rule_nxt;
   logic [TW-1:0] timer;
   logic          force_ok;
   logic          nxt_sel;
   logic          timed;

   assign state = st;

   // A force is honoured only toward a healthy source that is not already selected.
   assign force_ok = force_req && (force_sel != sel) && (force_sel ? !sec_fail : !pri_fail);
   assign timed    = (st == S_HOLD) || (st == S_WTR);

   always_comb begin
      rule_nxt = st;
      case (st)
         S_PRI:   if (pri_fail) rule_nxt = S_HOLD;
         S_HOLD: begin
            if (!pri_fail)               rule_nxt = S_PRI;
            else if (timer == HOLD_LAST) rule_nxt = S_SEC;
         end
         S_SEC: begin
            if (sec_fail)                     rule_nxt = S_PRI;
            else if (!pri_fail && revert_en)  rule_nxt = S_WTR;
         end
         S_WTR: begin
            if (pri_fail || !revert_en)           rule_nxt = S_SEC;
            else if (sec_fail || timer == WTR_LAST) rule_nxt = S_PRI;
         end
         default: rule_nxt = st;
      endcase
   end

   always_comb begin
      nxt = st;
      if (st == S_MUTE) begin
         if (!pri_fail)      nxt = S_PRI;
         else if (!sec_fail) nxt = S_SEC;
      end else if (pri_fail && sec_fail) begin
         nxt = S_MUTE;
      end else if (force_ok) begin
         nxt = force_sel ? S_SEC : S_PRI;
      end else begin
         nxt = rule_nxt;
      end
      nxt_sel = (nxt == S_MUTE) ? sel : ((nxt == S_SEC) || (nxt == S_WTR));
   end

   always_ff @(posedge FPGA_48MHz) begin
      if (FPGA_rst) begin
         st         <= S_PRI;
         timer      <= '0;
         sel        <= 1'b0;
         mute       <= 1'b0;
         switch_pls <= 1'b0;
         sw_cnt     <= '0;
         pri_alm    <= 1'b0;
         sec_alm    <= 1'b0;
      end else begin
         st         <= nxt;
         sel        <= nxt_sel;
         mute       <= (nxt == S_MUTE);
         switch_pls <= (nxt_sel != sel);
         if ((nxt != st) || !timed)
            timer <= '0;
         else if (timer != '1)
            timer <= timer + 1'b1;
         if (cnt_clr)
            sw_cnt <= '0;
         else if ((nxt_sel != sel) && (sw_cnt != 8'hFF))
            sw_cnt <= sw_cnt + 8'd1;
         pri_alm <= pri_fail | (pri_alm & ~alm_clr);
         sec_alm <= sec_fail | (sec_alm & ~alm_clr);
      end
   end

endmodule

// File: tb/tb_tdm_failover_ctrl.sv
// Directed bench for tdm_failover_ctrl: a rule-level reference model is compared every
// cycle, plus literal expectations for latencies, counts and state codes.
module tb_tdm_failover_ctrl;

   localparam int HOLD_CYC = 48;
   localparam int WTR_CYC  = 4800;
   localparam int PRI = 0, HOLD = 1, SEC = 2, WTR = 3, MUTE = 4;

   logic       clk = 1'b0;
   logic       rst, pri_fail, sec_fail, revert_en, force_req, force_sel, alm_clr, cnt_clr;
   logic       sel, mute, switch_pls, pri_alm, sec_alm;
   logic [7:0] sw_cnt;
   logic [2:0] state;

   int n_chk  = 0;
   int n_fail = 0;
   bit en     = 1'b0;

   // reference model state
   int m_st, m_age, m_cnt;
   bit m_sel, m_mute, m_pls, m_palm, m_salm;

   always #10 clk = ~clk;

   tdm_failover_ctrl #(.HOLD_CYC(HOLD_CYC), .WTR_CYC(WTR_CYC)) dut (
      .FPGA_48MHz(clk), .FPGA_rst(rst), .pri_fail(pri_fail), .sec_fail(sec_fail),
      .revert_en(revert_en), .force_req(force_req), .force_sel(force_sel),
      .alm_clr(alm_clr), .cnt_clr(cnt_clr), .sel(sel), .mute(mute),
      .switch_pls(switch_pls), .sw_cnt(sw_cnt), .pri_alm(pri_alm), .sec_alm(sec_alm),
      .state(state)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the state decides which source is selected; a switch is any change of that choice.
   always @(posedge clk) begin
      int nx;
      bit ns;
      if (rst) begin
         m_st = PRI; m_age = 0; m_cnt = 0;
         m_sel = 0; m_mute = 0; m_pls = 0; m_palm = 0; m_salm = 0;
      end else begin
         nx = m_st;
         if (m_st == MUTE) begin
            if (!pri_fail) nx = PRI;
            else if (!sec_fail) nx = SEC;
         end else if (pri_fail && sec_fail) begin
            nx = MUTE;
         end else if (force_req && (force_sel != m_sel) && !(force_sel ? sec_fail : pri_fail)) begin
            nx = force_sel ? SEC : PRI;
         end else begin
            if (m_st == PRI && pri_fail) nx = HOLD;
            if (m_st == HOLD) nx = !pri_fail ? PRI : (m_age == HOLD_CYC - 1) ? SEC : HOLD;
            if (m_st == SEC) nx = sec_fail ? PRI : (revert_en && !pri_fail) ? WTR : SEC;
            if (m_st == WTR)
               nx = (pri_fail || !revert_en) ? SEC : (sec_fail || m_age == WTR_CYC - 1) ? PRI : WTR;
         end
         ns     = (nx == MUTE) ? m_sel : (nx == SEC || nx == WTR);
         m_pls  = (ns != m_sel);
         m_sel  = ns;
         m_mute = (nx == MUTE);
         m_age  = (nx != m_st) ? 0 : m_age + 1;
         m_st   = nx;
         if (cnt_clr) m_cnt = 0;
         else if (m_pls && m_cnt < 255) m_cnt = m_cnt + 1;
         m_palm = pri_fail || (m_palm && !alm_clr);
         m_salm = sec_fail || (m_salm && !alm_clr);
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("model_state", 32'(state), 32'(m_st));
         chk("model_sel", 32'(sel), 32'(m_sel));
         chk("model_mute", 32'(mute), 32'(m_mute));
         chk("model_switch_pls", 32'(switch_pls), 32'(m_pls));
         chk("model_sw_cnt", 32'(sw_cnt), 32'(m_cnt));
         chk("model_pri_alm", 32'(pri_alm), 32'(m_palm));
         chk("model_sec_alm", 32'(sec_alm), 32'(m_salm));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for sel to reach a value, returning the number of edges taken (or -1 on timeout).
   task automatic wait_sel(input logic want, input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (sel === want) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      bit fs;
      rst = 1; pri_fail = 0; sec_fail = 0; revert_en = 0;
      force_req = 0; force_sel = 0; alm_clr = 0; cnt_clr = 0;
      tick();
      en = 1;
      pri_fail = 1;
      tick(); tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_cnt", 32'(sw_cnt), 0);
      chk("rst_pri_alm", 32'(pri_alm), 0);
      rst = 0;

      // debounce to secondary: entry edge plus HOLD_CYC timed edges
      wait_sel(1'b1, 100, n);
      chk("hold_latency", 32'(n), 49);
      chk("hold_pls", 32'(switch_pls), 1);
      chk("hold_cnt", 32'(sw_cnt), 1);
      chk("hold_pri_alm", 32'(pri_alm), 1);
      tick();
      chk("hold_pls_one_cycle", 32'(switch_pls), 0);
      chk("hold_state_sec", 32'(state), 2);

      // dual failure from SEC, then secondary recovers
      sec_fail = 1; tick();
      chk("mute_state", 32'(state), 4);
      chk("mute_flag", 32'(mute), 1);
      chk("mute_sel_held", 32'(sel), 1);
      sec_fail = 0; tick();
      chk("unmute_state", 32'(state), 2);
      chk("unmute_no_pls", 32'(switch_pls), 0);
      alm_clr = 1; tick(); alm_clr = 0;
      chk("alm_set_wins", 32'(pri_alm), 1);
      chk("alm_clr_sec", 32'(sec_alm), 0);

      // wait-to-restore full run
      revert_en = 1; pri_fail = 0;
      wait_sel(1'b0, 6000, n);
      chk("wtr_latency", 32'(n), 4801);
      chk("wtr_pls", 32'(switch_pls), 1);
      chk("wtr_cnt", 32'(sw_cnt), 2);
      alm_clr = 1; tick(); alm_clr = 0;
      chk("alm_clr_pri", 32'(pri_alm), 0);

      // wait-to-restore aborted by primary failing again
      pri_fail = 1;
      wait_sel(1'b1, 100, n);
      chk("hold_latency_2", 32'(n), 49);
      pri_fail = 0;
      repeat (2000) tick();
      chk("wtr_mid_state", 32'(state), 3);
      pri_fail = 1; tick();
      chk("wtr_abort_state", 32'(state), 2);
      chk("wtr_abort_no_pls", 32'(switch_pls), 0);
      chk("wtr_abort_cnt", 32'(sw_cnt), 3);

      // manual forcing
      revert_en = 0; pri_fail = 0;
      force_req = 1; force_sel = 0; tick(); force_req = 0;
      chk("force_pri", 32'(state), 0);
      force_req = 1; force_sel = 1; tick(); force_req = 0;
      chk("force_sec_state", 32'(state), 2);
      chk("force_sec_sel", 32'(sel), 1);
      force_req = 1; force_sel = 1; tick(); force_req = 0;
      chk("force_same_ignored", 32'(switch_pls), 0);
      force_req = 1; force_sel = 0; tick(); force_req = 0;
      sec_fail = 1; force_req = 1; force_sel = 1; tick(); force_req = 0;
      chk("force_failed_ignored", 32'(state), 0);
      chk("force_failed_no_pls", 32'(switch_pls), 0);
      sec_fail = 0;

      // 20-cycle glitch on primary is rejected
      cnt_clr = 1; tick(); cnt_clr = 0;
      chk("cnt_clr", 32'(sw_cnt), 0);
      pri_fail = 1; repeat (20) tick();
      chk("glitch_hold", 32'(state), 1);
      pri_fail = 0; tick();
      chk("glitch_state", 32'(state), 0);
      chk("glitch_sel", 32'(sel), 0);
      chk("glitch_cnt", 32'(sw_cnt), 0);

      // reset in the middle of HOLD
      pri_fail = 1; repeat (10) tick();
      rst = 1; tick(); rst = 0; pri_fail = 0;
      chk("rst_hold_state", 32'(state), 0);
      chk("rst_hold_no_pls", 32'(switch_pls), 0);
      tick();

      // counter saturation and clear-over-increment
      fs = 1;
      for (int i = 0; i < 260; i++) begin
         force_req = 1; force_sel = fs; tick();
         fs = !fs;
      end
      force_req = 0; tick();
      chk("cnt_saturated", 32'(sw_cnt), 255);
      chk("cnt_sat_state", 32'(state), 0);
      cnt_clr = 1; force_req = 1; force_sel = 1; tick();
      cnt_clr = 0; force_req = 0;
      chk("cnt_clr_wins", 32'(sw_cnt), 0);
      chk("cnt_clr_pls", 32'(switch_pls), 1);
      tick();

      @(posedge clk);
      en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
